// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

   localparam int          INSTR_W = 32;
   localparam logic [31:0] PC_INC  = 32'd4;

   typedef struct packed {
      logic [31:0]        pc;
      logic [INSTR_W-1:0] data;
      logic               filled;
   } fetch_entry_t;

   // Ceiling log2 for sizing queue pointers; DEPTH is a power of 2.
   function automatic int depth_log2(input int depth);
      depth_log2 = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < depth) depth_log2 = i + 1;
      end
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// In-order fetch buffer: entries are allocated at request time, filled by
// memory responses in request order, and popped by decode.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int AW    = depth_log2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               flush,
   input  logic               alloc,
   input  logic [31:0]        alloc_pc,
   input  logic               fill,
   input  logic [INSTR_W-1:0] fill_data,
   input  logic               pop,
   output logic               head_valid,
   output logic [31:0]        head_pc,
   output logic [INSTR_W-1:0] head_data,
   output logic [CW-1:0]      alloc_count,
   output logic [CW-1:0]      unfilled_count
);

   fetch_entry_t  entries [DEPTH];
   logic [AW-1:0] alloc_ptr;
   logic [AW-1:0] fill_ptr;
   logic [AW-1:0] pop_ptr;
   logic          do_alloc;
   logic          do_fill;
   logic          do_pop;

   assign head_valid = (alloc_count != '0) && entries[pop_ptr].filled;
   assign head_pc    = entries[pop_ptr].pc;
   assign head_data  = entries[pop_ptr].data;

   // Guards keep a misbehaving neighbour from corrupting pointers.
   assign do_alloc = alloc && (alloc_count != CW'(DEPTH));
   assign do_fill  = fill && (unfilled_count != '0);
   assign do_pop   = pop && head_valid;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
         alloc_ptr      <= '0;
         fill_ptr       <= '0;
         pop_ptr        <= '0;
         alloc_count    <= '0;
         unfilled_count <= '0;
      end else if (flush) begin
         for (int i = 0; i < DEPTH; i++) entries[i].filled <= 1'b0;
         alloc_ptr      <= '0;
         fill_ptr       <= '0;
         pop_ptr        <= '0;
         alloc_count    <= '0;
         unfilled_count <= '0;
      end else begin
         if (do_alloc) begin
            entries[alloc_ptr].pc     <= alloc_pc;
            entries[alloc_ptr].data   <= '0;
            entries[alloc_ptr].filled <= 1'b0;
            alloc_ptr                 <= alloc_ptr + AW'(1);
         end
         if (do_fill) begin
            entries[fill_ptr].data   <= fill_data;
            entries[fill_ptr].filled <= 1'b1;
            fill_ptr                 <= fill_ptr + AW'(1);
         end
         if (do_pop) pop_ptr <= pop_ptr + AW'(1);
         alloc_count    <= alloc_count + CW'(do_alloc) - CW'(do_pop);
         unfilled_count <= unfilled_count + CW'(do_alloc) - CW'(do_fill);
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues sequential fetches, buffers
// returned words for decode, and squashes in-flight work on a taken branch.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 4
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               redirect,
   input  logic [31:0]        redirect_pc,
   output logic               imem_req_valid,
   output logic [31:0]        imem_req_addr,
   input  logic               imem_req_ready,
   input  logic               imem_resp_valid,
   input  logic [INSTR_W-1:0] imem_resp_data,
   output logic               inst_valid,
   output logic [INSTR_W-1:0] inst_data,
   output logic [31:0]        inst_pc,
   input  logic               inst_ready
);

   localparam int CW = depth_log2(DEPTH) + 1;

   logic [31:0]   pc;
   logic [CW-1:0] squash;
   logic [CW-1:0] alloc_count;
   logic [CW-1:0] unfilled_count;
   logic [CW:0]   in_flight;
   logic          accept;
   logic          resp_squash;
   logic          resp_fill;

   // Squashed responses still occupy memory slots, so they count against DEPTH.
   assign in_flight      = {1'b0, alloc_count} + {1'b0, squash};
   assign imem_req_valid = !reset && !redirect && (in_flight < (CW + 1)'(DEPTH));
   assign imem_req_addr  = pc;
   assign accept         = imem_req_valid && imem_req_ready;

   assign resp_squash = imem_resp_valid && (squash != '0);
   assign resp_fill   = imem_resp_valid && (squash == '0) && (unfilled_count != '0);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pc     <= RESET_PC;
         squash <= '0;
      end else if (redirect) begin
         pc     <= {redirect_pc[31:2], 2'b00};
         squash <= squash + unfilled_count - CW'(resp_squash || resp_fill);
      end else begin
         if (accept) pc <= pc + PC_INC;
         if (resp_squash) squash <= squash - CW'(1);
      end
   end

   fetch_queue #(
      .DEPTH (DEPTH)
   ) u_queue (
      .clock          (clock),
      .reset          (reset),
      .flush          (redirect),
      .alloc          (accept),
      .alloc_pc       (pc),
      .fill           (resp_fill),
      .fill_data      (imem_resp_data),
      .pop            (inst_ready),
      .head_valid     (inst_valid),
      .head_pc        (inst_pc),
      .head_data      (inst_data),
      .alloc_count    (alloc_count),
      .unfilled_count (unfilled_count)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming/stall vector table plus redirect,
// PC wrap and mid-stream reset sequences against a behavioural memory.
module tb_fetch_unit;
   import fetch_pkg::*;

   logic               clock = 1'b0;
   logic               reset = 1'b1;
   logic               redirect = 1'b0;
   logic [31:0]        redirect_pc = '0;
   logic               imem_req_valid;
   logic [31:0]        imem_req_addr;
   logic               imem_req_ready = 1'b1;
   logic               imem_resp_valid = 1'b0;
   logic [INSTR_W-1:0] imem_resp_data = '0;
   logic               inst_valid;
   logic [INSTR_W-1:0] inst_data;
   logic [31:0]        inst_pc;
   logic               inst_ready = 1'b0;

   logic               req_valid2;
   logic [31:0]        req_addr2;
   logic               inst_valid2;
   logic [INSTR_W-1:0] inst_data2;
   logic [31:0]        inst_pc2;

   fetch_unit dut (
      .clock           (clock),
      .reset           (reset),
      .redirect        (redirect),
      .redirect_pc     (redirect_pc),
      .imem_req_valid  (imem_req_valid),
      .imem_req_addr   (imem_req_addr),
      .imem_req_ready  (imem_req_ready),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .inst_valid      (inst_valid),
      .inst_data       (inst_data),
      .inst_pc         (inst_pc),
      .inst_ready      (inst_ready)
   );

   // Second instance only exercises PC wrap from a high reset PC.
   fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
      .clock           (clock),
      .reset           (reset),
      .redirect        (1'b0),
      .redirect_pc     (32'h0),
      .imem_req_valid  (req_valid2),
      .imem_req_addr   (req_addr2),
      .imem_req_ready  (1'b1),
      .imem_resp_valid (1'b0),
      .imem_resp_data  (32'h0),
      .inst_valid      (inst_valid2),
      .inst_data       (inst_data2),
      .inst_pc         (inst_pc2),
      .inst_ready      (1'b0)
   );

   always #5 clock = ~clock;

   int compared = 0;
   int mismatched = 0;
   int cyc = 0;
   int lat = 1;
   logic [31:0] mem_addr_q [$];
   int          mem_due_q  [$];

   typedef struct {
      logic        rdy;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic        exp_iv;
      logic [31:0] exp_pc;
   } vec_t;
   vec_t tbl [16];

   function automatic logic [INSTR_W-1:0] word_of(input logic [31:0] a);
      return a ^ 32'h1234_5678;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Memory accepts at the sampling point, answers lat cycles later in order.
   task automatic sample_edge();
      @(negedge clock);
      if (imem_req_valid && imem_req_ready) begin
         mem_addr_q.push_back(imem_req_addr);
         mem_due_q.push_back(cyc + lat);
      end
   endtask

   task automatic advance();
      @(posedge clock);
      #1;
      cyc++;
      if (mem_addr_q.size() > 0 && mem_due_q[0] <= cyc) begin
         imem_resp_valid = 1'b1;
         imem_resp_data  = word_of(mem_addr_q.pop_front());
         void'(mem_due_q.pop_front());
      end else begin
         imem_resp_valid = 1'b0;
         imem_resp_data  = '0;
      end
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      redirect = 1'b0;
      inst_ready = 1'b0;
      imem_resp_valid = 1'b0;
      mem_addr_q.delete();
      mem_due_q.delete();
      repeat (2) @(posedge clock);
      @(negedge clock);
      check("rst_req_valid", 32'(imem_req_valid), 32'h0);
      check("rst_inst_valid", 32'(inst_valid), 32'h0);
      check("rst_req_addr", imem_req_addr, 32'h0);
      check("rst_wrap_addr", req_addr2, 32'hFFFF_FFF8);
      @(posedge clock);
      #1;
      reset = 1'b0;
      cyc = 0;
   endtask

   always @(negedge clock) begin
      if (!reset && imem_resp_valid) begin
         assert (dut.squash != '0 || dut.unfilled_count != '0)
         else begin
            mismatched++;
            $display("FAIL resp_protocol: response with nothing outstanding at cycle %0d", cyc);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] got_pc [$];
      logic [31:0] got_data [$];
      int          first_cyc;

      tbl[0]  = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
      tbl[1]  = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
      tbl[2]  = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
      tbl[3]  = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
      tbl[4]  = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
      tbl[5]  = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h0C};
      tbl[6]  = '{1'b0, 1'b1, 32'h18, 1'b1, 32'h10};
      tbl[7]  = '{1'b0, 1'b1, 32'h1C, 1'b1, 32'h10};
      tbl[8]  = '{1'b0, 1'b0, 32'h20, 1'b1, 32'h10};
      tbl[9]  = '{1'b0, 1'b0, 32'h20, 1'b1, 32'h10};
      tbl[10] = '{1'b1, 1'b0, 32'h20, 1'b1, 32'h10};
      tbl[11] = '{1'b1, 1'b1, 32'h20, 1'b1, 32'h14};
      tbl[12] = '{1'b1, 1'b1, 32'h24, 1'b1, 32'h18};
      tbl[13] = '{1'b1, 1'b1, 32'h28, 1'b1, 32'h1C};
      tbl[14] = '{1'b1, 1'b1, 32'h2C, 1'b1, 32'h20};
      tbl[15] = '{1'b1, 1'b1, 32'h30, 1'b1, 32'h24};

      // Streaming, stall until DEPTH entries are held, then release.
      lat = 1;
      apply_reset();
      for (int i = 0; i < 16; i++) begin
         inst_ready = tbl[i].rdy;
         sample_edge();
         check($sformatf("row%0d req_valid", i), 32'(imem_req_valid), 32'(tbl[i].exp_req));
         check($sformatf("row%0d req_addr", i), imem_req_addr, tbl[i].exp_addr);
         check($sformatf("row%0d inst_valid", i), 32'(inst_valid), 32'(tbl[i].exp_iv));
         if (tbl[i].exp_iv) begin
            check($sformatf("row%0d inst_pc", i), inst_pc, tbl[i].exp_pc);
            check($sformatf("row%0d inst_data", i), inst_data, word_of(tbl[i].exp_pc));
         end
         if (i < 4) begin
            check($sformatf("wrap%0d req_valid", i), 32'(req_valid2), 32'h1);
            check($sformatf("wrap%0d req_addr", i), req_addr2, 32'hFFFF_FFF8 + 32'(4 * i));
            check($sformatf("wrap%0d idle", i), inst_valid2 ? (inst_pc2 | inst_data2 | 32'h1) : 32'h0, 32'h0);
         end
         advance();
      end

      // Redirect with three fetches outstanding in a 3-cycle memory.
      lat = 3;
      apply_reset();
      inst_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         sample_edge();
         check($sformatf("lat3 c%0d req_valid", i), 32'(imem_req_valid), 32'h1);
         check($sformatf("lat3 c%0d req_addr", i), imem_req_addr, 32'(4 * i));
         advance();
      end
      redirect = 1'b1;
      redirect_pc = 32'h0000_0103;
      sample_edge();
      check("redir_cycle req_valid", 32'(imem_req_valid), 32'h0);
      advance();
      redirect = 1'b0;
      first_cyc = -1;
      for (int k = 0; k < 24; k++) begin
         sample_edge();
         if (k == 0) begin
            check("redir_next req_valid", 32'(imem_req_valid), 32'h1);
            check("redir_next req_addr", imem_req_addr, 32'h0000_0100);
         end
         if (inst_valid) begin
            if (first_cyc < 0) first_cyc = cyc;
            got_pc.push_back(inst_pc);
            got_data.push_back(inst_data);
         end
         advance();
      end
      check("redir_delivered_enough", 32'(got_pc.size() >= 4), 32'h1);
      check("redir_first_cycle", 32'(first_cyc), 32'd8);
      for (int k = 0; k < 4 && k < got_pc.size(); k++) begin
         check($sformatf("redir_pc%0d", k), got_pc[k], 32'h100 + 32'(4 * k));
         check($sformatf("redir_data%0d", k), got_data[k], word_of(32'h100 + 32'(4 * k)));
      end

      // Reset asserted mid-cycle with instructions queued.
      lat = 1;
      apply_reset();
      for (int i = 0; i < 2; i++) begin
         sample_edge();
         advance();
      end
      sample_edge();
      check("pre_reset inst_valid", 32'(inst_valid), 32'h1);
      check("pre_reset inst_pc", inst_pc, 32'h0);
      #2;
      reset = 1'b1;
      #1;
      check("mid_reset inst_valid", 32'(inst_valid), 32'h0);
      check("mid_reset req_valid", 32'(imem_req_valid), 32'h0);
      check("mid_reset req_addr", imem_req_addr, 32'h0);
      mem_addr_q.delete();
      mem_due_q.delete();
      imem_resp_valid = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      cyc = 0;
      inst_ready = 1'b1;
      sample_edge();
      check("post_reset req_valid", 32'(imem_req_valid), 32'h1);
      check("post_reset req_addr", imem_req_addr, 32'h0);
      check("post_reset inst_valid", 32'(inst_valid), 32'h0);
      advance();
      sample_edge();
      check("post_reset c1 req_addr", imem_req_addr, 32'h4);
      check("post_reset c1 inst_valid", 32'(inst_valid), 32'h0);
      advance();
      sample_edge();
      check("post_reset c2 inst_valid", 32'(inst_valid), 32'h1);
      check("post_reset c2 inst_pc", inst_pc, 32'h0);
      advance();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the MIPS datapath. Owns the architectural PC register and issues sequential fetches to instruction memory through a valid/ready request port. Returned instructions are buffered together with their PC in a small in-order queue feeding decode. A taken branch from the branch-resolution stage (branch-target adder plus `ANDBranch`) redirects the PC and squashes all younger in-flight work.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0
- `DEPTH`, 4, queue entries and maximum in-flight fetches; power of 2, ≥ 2

- `clock`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `redirect`  in  1  taken branch; load `redirect_pc` this cycle
- `redirect_pc`  in  32  branch target; bits [1:0] ignored (treated as 0)
- `imem_req_valid`  out  1  fetch request valid
- `imem_req_addr`  out  32  fetch address (= PC register)
- `imem_req_ready`  in  1  memory accepts request
- `imem_resp_valid`  in  1  one response word, strictly in request order
- `imem_resp_data`  in  32  instruction word
- `inst_valid`  out  1  head instruction available to decode
- `inst_data`  out  32  head instruction word
- `inst_pc`  out  32  PC of head instruction
- `inst_ready`  in  1  decode consumes head

## Operation
- State: `pc`, queue of `DEPTH` entries {pc, data, filled}, `squash` counter (0..DEPTH).
- Request: `imem_req_valid` = (entries_allocated + squash < DEPTH) and not `redirect`. Accept = valid & ready. On accept: allocate tail entry with pc = `pc`, filled = 0; `pc` <= `pc` + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- Response: if `squash` > 0, discard word and decrement `squash`; else write data into oldest unfilled entry and set filled.
- Output: `inst_valid` = head entry allocated and filled; `inst_data`/`inst_pc` from head. Pop on `inst_valid & inst_ready`.
- Redirect (highest priority): `pc` <= {`redirect_pc`[31:2], 2'b00}; all entries cleared; `squash` <= squash + unfilled_entries − (response this cycle). No request is issued in the redirect cycle; a pop in that cycle is discarded with the flush.
- Responses arriving with no unfilled entry and `squash` = 0 are a protocol violation; must not corrupt state (dropped), flagged by a bench assertion.
- Simultaneous accept + response + pop in one non-redirect cycle all take effect; the occupancy arithmetic is exact.

## Timing
- Reset values: `pc` = `RESET_PC`, queue empty, `squash` = 0, `inst_valid` = 0, `imem_req_valid` = 0 while `reset` is high, 1 in the first cycle after release (with `imem_req_addr` = `RESET_PC`).
- `imem_req_valid` and `imem_req_addr` depend only on registered state and `redirect`, never on `imem_req_ready`.
- Minimum latency: request accepted in cycle N, response in N+1, `inst_valid` = 1 in N+2.
- Steady-state throughput of 1 instruction/cycle with single-cycle memory and `inst_ready` held high.
- After a redirect in cycle N: first request to the target is issued in N+1; no pre-redirect word ever reaches `inst_valid`.
- Reset mid-operation: immediate return to reset values; outstanding memory responses are the memory's responsibility to drop.

## Structure
- Package `fetch_pkg`: `INSTR_W` = 32, `PC_INC` = 4, entry typedef {pc, data, filled}, `DEPTH` log2 helper.
- Sub-module `fetch_queue`: entry array with alloc/fill/pop pointers, flush, and allocated/unfilled counts. `fetch_unit` holds the PC, the squash counter, and the request/redirect logic.

## Test plan
- Reset release, memory always ready with 1-cycle latency, decode always ready -> addresses 0, 4, 8, …; `inst_pc`/`inst_data` pairs in order, one per cycle from cycle 2.
- `inst_ready` = 0 -> exactly `DEPTH` (4) requests are issued, then `imem_req_valid` = 0; release -> 4 instructions in order, fetching resumes.
- Memory with 3-cycle latency, redirect to 32'h0000_0100 while 3 requests are in flight -> 3 responses discarded; first delivered `inst_pc` = 0x100.
- `redirect_pc` = 32'h0000_0103 -> `imem_req_addr` = 0x100 next cycle.
- `RESET_PC` = 32'hFFFF_FFF8 -> fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Assert `reset` mid-stream with 2 entries queued -> `inst_valid` drops immediately; first request after release is to `RESET_PC`.
